// File: rtl/seq_alu_unit.sv
// seq_alu_unit: multi-cycle execute ALU; single-cycle arithmetic/logic ops,
// SLL/SRL via an iterative 1-bit-per-cycle shifter, valid/ready on both sides.
module seq_alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);
  localparam int SHW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [SHW-1:0] cnt;
  logic [SHW-1:0] shamt;
  logic [WIDTH-1:0] acc, acc_n, op_y;
  logic dir, armed, is_shift;
  assign in_ready = (state == IDLE) && armed;
  assign out_valid = (state == DONE);
  assign shamt = src_b[SHW-1:0];
  assign is_shift = (alu_control[1:0] == 2'b01);
  assign acc_n = dir ? acc >> 1 : acc << 1;
  assign op_y = alu_control == 3'b000 ? src_a + src_b :
                alu_control == 3'b010 ? src_a - src_b :
                alu_control == 3'b100 ? src_a ^ src_b :
                alu_control == 3'b110 ? src_a | src_b :
                alu_control == 3'b111 ? src_a & src_b : '0;
  // acc holds the shift in progress so result/zero only change on entry to DONE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      dir    <= 1'b0;
      armed  <= 1'b0;
      result <= '0;
      zero   <= 1'b1;
    end else begin
      armed <= 1'b1;
      if (flush) begin
        state <= IDLE;
        cnt   <= '0;
      end else
        case (state)
          IDLE:
            if (in_valid && in_ready) begin
              if (!is_shift) begin
                result <= op_y;
                zero   <= (op_y == '0);
                state  <= DONE;
              end else if (shamt == '0) begin
                result <= src_a;
                zero   <= (src_a == '0);
                state  <= DONE;
              end else begin
                acc   <= src_a;
                cnt   <= shamt;
                dir   <= alu_control[2];
                state <= SHIFT;
              end
            end
          SHIFT: begin
            acc <= acc_n;
            cnt <= cnt - 1'b1;
            if (cnt == SHW'(1)) begin
              result <= acc_n;
              zero   <= (acc_n == '0);
              state  <= DONE;
            end
          end
          DONE: if (out_ready) state <= IDLE;
          default: state <= IDLE;
        endcase
    end
endmodule
